// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// register map, scan state encoding and the active-low hex segment table.
package seg7_pkg;

  // Register map (2-bit word address)
  localparam logic [1:0] ADDR_VALUE    = 2'd0;
  localparam logic [1:0] ADDR_DIGIT_EN = 2'd1;
  localparam logic [1:0] ADDR_DP_MASK  = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble + decimal point to active-low cathode pattern.
// Output bit 7 is the dp segment, bits 6:0 are g..a.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathodes
);

  // dp is lit (driven low) when requested; segments come from the table
  assign cathodes = {~dp, HEX_LUT[nibble]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment controller with a small register
// file. Each digit slot starts with a short all-anodes-off gap to hide
// ghosting, then lights the digit. Display data is latched into shadow
// registers at the start of every frame so bus writes never tear a frame.
//
// Bus handshake: wr_en and rd_en are single-cycle strobes with no
// back-pressure; a write lands on the edge where wr_en is high, and a read
// returns the pre-edge register contents on rd_data one cycle after rd_en.
// rd_data holds its value while rd_en is low.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  // Cycles per digit slot; must exceed BLANK_CYCLES + 1
  parameter int DIGIT_CYCLES = CLK_FREQ / 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [7:0]  AN,
  output logic [7:0]  cathodes,
  output scan_state_t state_dbg
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_CYCLES - BLANK_CYCLES - 1);

  // Bus-visible registers
  logic [31:0] value_r;
  logic [7:0]  digit_en_r;
  logic [7:0]  dp_mask_r;
  logic        enable_r;

  // Frame-stable copies used for decoding
  logic [31:0] sh_value;
  logic [7:0]  sh_digit_en;
  logic [7:0]  sh_dp_mask;

  // Sequencer
  scan_state_t      state;
  logic [2:0]       digit;
  logic [CNT_W-1:0] cnt;

  // Decoder feed for the digit about to enter BLANK
  logic        advance_digit;
  logic [2:0]  dec_digit;
  logic [31:0] dec_value;
  logic [7:0]  dec_dp_mask;
  logic [3:0]  dec_nibble;
  logic        dec_dp;
  logic [7:0]  dec_code;
  logic        enable_next;

  assign state_dbg = state;

  // ENABLE as it will be after this edge, so a CTRL write acts on the same
  // edge that stores it
  always_comb begin
    enable_next = enable_r;
    if (wr_en && (addr == ADDR_CTRL)) begin
      enable_next = wr_data[0];
    end
  end

  // Register file writes; unused upper bits are simply not stored
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      value_r    <= 32'h0;
      digit_en_r <= 8'hFF;
      dp_mask_r  <= 8'h00;
      enable_r   <= 1'b0;
    end else if (wr_en) begin
      case (addr)
        ADDR_VALUE:    value_r    <= wr_data;
        ADDR_DIGIT_EN: digit_en_r <= wr_data[7:0];
        ADDR_DP_MASK:  dp_mask_r  <= wr_data[7:0];
        default:       enable_r   <= wr_data[0];
      endcase
    end
  end

  // Registered read port; returns pre-write contents on a same-cycle write
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      rd_data <= 32'h0;
    end else if (rd_en) begin
      case (addr)
        ADDR_VALUE:    rd_data <= value_r;
        ADDR_DIGIT_EN: rd_data <= {24'h0, digit_en_r};
        ADDR_DP_MASK:  rd_data <= {24'h0, dp_mask_r};
        default:       rd_data <= {31'h0, enable_r};
      endcase
    end
  end

  // Select which digit and which data source the next BLANK preload uses.
  // Moving within a frame uses the shadows; starting a frame (from IDLE or
  // on the 7->0 wrap) uses the live registers that are being shadowed.
  always_comb begin
    advance_digit = (state == SHOW) && (digit != 3'd7);
    dec_digit     = 3'd0;
    dec_value     = value_r;
    dec_dp_mask   = dp_mask_r;
    if (advance_digit) begin
      dec_digit   = digit + 3'd1;
      dec_value   = sh_value;
      dec_dp_mask = sh_dp_mask;
    end
    dec_nibble = dec_value[{dec_digit, 2'b00} +: 4];
    dec_dp     = dec_dp_mask[dec_digit];
  end

  seg7_hex_decoder u_hex_decoder (
    .nibble   (dec_nibble),
    .dp       (dec_dp),
    .cathodes (dec_code)
  );

  // Scan sequencer with registered AN/cathodes; cathodes are loaded once at
  // slot start and held through BLANK and SHOW
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= IDLE;
      digit       <= 3'd0;
      cnt         <= '0;
      AN          <= 8'hFF;
      cathodes    <= 8'hFF;
      sh_value    <= 32'h0;
      sh_digit_en <= 8'hFF;
      sh_dp_mask  <= 8'h00;
    end else if (!enable_next) begin
      state    <= IDLE;
      digit    <= 3'd0;
      cnt      <= '0;
      AN       <= 8'hFF;
      cathodes <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          state       <= BLANK;
          digit       <= 3'd0;
          cnt         <= '0;
          AN          <= 8'hFF;
          cathodes    <= dec_code;
          sh_value    <= value_r;
          sh_digit_en <= digit_en_r;
          sh_dp_mask  <= dp_mask_r;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            // A disabled digit still burns its slot with anodes off
            AN    <= sh_digit_en[digit] ? ~(8'h01 << digit) : 8'hFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state    <= BLANK;
            cnt      <= '0;
            digit    <= digit + 3'd1;
            AN       <= 8'hFF;
            cathodes <= dec_code;
            if (digit == 3'd7) begin
              sh_value    <= value_r;
              sh_digit_en <= digit_en_r;
              sh_dp_mask  <= dp_mask_r;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          digit    <= 3'd0;
          cnt      <= '0;
          AN       <= 8'hFF;
          cathodes <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with a 16-cycle slot and 2-cycle blank gap.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int DC = 16;
  localparam int BC = 2;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  AN;
  logic [7:0]  cathodes;
  scan_state_t state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic [6:0]  seg_tab [16];

  seg7_scan_ctrl #(
    .CLK_FREQ     (16000),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .AN        (AN),
    .cathodes  (cathodes),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk_sys = ~clk_sys;

  // ---------------- driver tasks (called at a falling edge, return at one)
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk_sys);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a);
    rd_en = 1'b1; addr = a;
    @(negedge clk_sys);
    rd_en = 1'b0;
  endtask

  // Expected {AN, cathodes} for scan cycles [first, first+n) after enable
  task automatic push_cycles(input logic [31:0] value, input logic [7:0] en,
                             input logic [7:0] dp, input int first, input int n);
    int d, off;
    logic [7:0] an_e;
    logic [7:0] cath_e;
    for (int c = first; c < first + n; c++) begin
      d    = (c / DC) % 8;
      off  = c % DC;
      an_e = 8'hFF;
      if (off >= BC && en[d]) an_e[d] = 1'b0;
      cath_e = {~dp[d], seg_tab[value[4*d +: 4]]};
      exp_q.push_back({an_e, cath_e});
    end
  endtask

  task automatic push_idle(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(16'hFFFF);
  endtask

  // ---------------- tests
  task automatic test_reset();
    if (AN !== 8'hFF) begin miscompares++; $display("FAIL reset_an: got %h want ff", AN); end
    vectors++;
    if (cathodes !== 8'hFF) begin miscompares++; $display("FAIL reset_cath: got %h want ff", cathodes); end
    vectors++;
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd: got %h want 0", rd_data); end
    vectors++;
    if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    vectors++;
    read_reg(ADDR_VALUE);
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_value: got %h want 0", rd_data); end
    vectors++;
    read_reg(ADDR_DP_MASK);
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_dp: got %h want 0", rd_data); end
    vectors++;
    read_reg(ADDR_CTRL);
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h want 0", rd_data); end
    vectors++;
    read_reg(ADDR_DIGIT_EN);
    if (rd_data !== 32'h0000_00FF) begin miscompares++; $display("FAIL reset_den: got %h want 000000ff", rd_data); end
    vectors++;
    repeat (3) @(negedge clk_sys);
    if (rd_data !== 32'h0000_00FF) begin miscompares++; $display("FAIL rd_hold: got %h want 000000ff", rd_data); end
    vectors++;
  endtask

  task automatic test_registers();
    write_reg(ADDR_DIGIT_EN, 32'hFFFF_FF5A);
    read_reg(ADDR_DIGIT_EN);
    if (rd_data !== 32'h0000_005A) begin miscompares++; $display("FAIL den_mask: got %h want 0000005a", rd_data); end
    vectors++;
    write_reg(ADDR_DP_MASK, 32'h1234_56C3);
    read_reg(ADDR_DP_MASK);
    if (rd_data !== 32'h0000_00C3) begin miscompares++; $display("FAIL dp_mask: got %h want 000000c3", rd_data); end
    vectors++;
    write_reg(ADDR_VALUE, 32'hDEAD_BEEF);
    read_reg(ADDR_VALUE);
    if (rd_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL value_rw: got %h want deadbeef", rd_data); end
    vectors++;
    write_reg(ADDR_CTRL, 32'hFFFF_FFFE);
    read_reg(ADDR_CTRL);
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL ctrl_mask: got %h want 0", rd_data); end
    vectors++;
    if ({AN, cathodes} !== 16'hFFFF) begin miscompares++; $display("FAIL ctrl_off_out: got %h want ffff", {AN, cathodes}); end
    vectors++;
    // write and read same address in one cycle: old contents come back
    wr_en = 1'b1; rd_en = 1'b1; addr = ADDR_VALUE; wr_data = 32'h0BAD_F00D;
    @(negedge clk_sys);
    wr_en = 1'b0; rd_en = 1'b0;
    if (rd_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_rd_same: got %h want deadbeef", rd_data); end
    vectors++;
    read_reg(ADDR_VALUE);
    if (rd_data !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL wr_rd_after: got %h want 0badf00d", rd_data); end
    vectors++;
    write_reg(ADDR_VALUE, 32'h0);
    write_reg(ADDR_DIGIT_EN, 32'hFF);
    write_reg(ADDR_DP_MASK, 32'h0);
  endtask

  task automatic test_basic_scan();
    logic [15:0] e;
    write_reg(ADDR_CTRL, 32'h1);
    if (state_dbg !== BLANK) begin miscompares++; $display("FAIL basic_state: got %0d want BLANK", state_dbg); end
    vectors++;
    push_cycles(32'h0, 8'hFF, 8'h00, 0, 2 * DC + 2);
    for (int i = 0; i < 2 * DC + 2; i++) begin
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL basic cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL basic cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
      @(negedge clk_sys);
    end
    write_reg(ADDR_CTRL, 32'h0);
    if ({AN, cathodes} !== 16'hFFFF) begin miscompares++; $display("FAIL basic_off: got %h want ffff", {AN, cathodes}); end
    vectors++;
  endtask

  task automatic test_pattern();
    logic [15:0] e;
    write_reg(ADDR_VALUE, 32'h8000_00F1);
    write_reg(ADDR_DP_MASK, 32'h80);
    write_reg(ADDR_CTRL, 32'h1);
    push_cycles(32'h8000_00F1, 8'hFF, 8'h80, 0, 9 * DC);
    for (int i = 0; i < 9 * DC; i++) begin
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL pattern cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL pattern cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
      @(negedge clk_sys);
    end
    write_reg(ADDR_CTRL, 32'h0);
    write_reg(ADDR_DP_MASK, 32'h0);
  endtask

  task automatic test_digit_en();
    logic [15:0] e;
    write_reg(ADDR_VALUE, 32'h7654_3210);
    write_reg(ADDR_DIGIT_EN, 32'h01);
    write_reg(ADDR_CTRL, 32'h1);
    push_cycles(32'h7654_3210, 8'h01, 8'h00, 0, 8 * DC + 4);
    for (int i = 0; i < 8 * DC + 4; i++) begin
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL digit_en cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL digit_en cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
      @(negedge clk_sys);
    end
    write_reg(ADDR_CTRL, 32'h0);
    write_reg(ADDR_DIGIT_EN, 32'hFF);
  endtask

  task automatic test_shadow();
    logic [15:0] e;
    write_reg(ADDR_VALUE, 32'h7654_3210);
    write_reg(ADDR_CTRL, 32'h1);
    push_cycles(32'h7654_3210, 8'hFF, 8'h00, 0, 8 * DC);
    push_cycles(32'h0000_0001, 8'hFF, 8'h00, 8 * DC, 8 * DC);
    for (int i = 0; i < 16 * DC; i++) begin
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL shadow cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL shadow cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
      // cycle 53 is inside digit 3's lit phase
      if (i == 3 * DC + BC + 3) begin wr_en = 1'b1; addr = ADDR_VALUE; wr_data = 32'h1; end
      if (i == 3 * DC + BC + 4) wr_en = 1'b0;
      @(negedge clk_sys);
    end
    write_reg(ADDR_CTRL, 32'h0);
  endtask

  task automatic test_disable_mid();
    logic [15:0] e;
    int cut;
    cut = 5 * DC + BC + 4;
    write_reg(ADDR_VALUE, 32'h89AB_CDEF);
    write_reg(ADDR_CTRL, 32'h1);
    push_cycles(32'h89AB_CDEF, 8'hFF, 8'h00, 0, cut + 1);
    push_idle(5);
    for (int i = 0; i < cut + 6; i++) begin
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL disable cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL disable cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
      if (i == cut) begin wr_en = 1'b1; addr = ADDR_CTRL; wr_data = 32'h0; end
      if (i == cut + 1) wr_en = 1'b0;
      @(negedge clk_sys);
    end
    write_reg(ADDR_CTRL, 32'h1);
    push_cycles(32'h89AB_CDEF, 8'hFF, 8'h00, 0, DC + 4);
    for (int i = 0; i < DC + 4; i++) begin
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL reenable cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL reenable cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
      @(negedge clk_sys);
    end
    write_reg(ADDR_CTRL, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    write_reg(ADDR_VALUE, 32'h1234_5678);
    read_reg(ADDR_VALUE);
    if (rd_data !== 32'h1234_5678) begin miscompares++; $display("FAIL rst_pre_rd: got %h want 12345678", rd_data); end
    vectors++;
    write_reg(ADDR_CTRL, 32'h1);
    push_cycles(32'h1234_5678, 8'hFF, 8'h00, 0, 2 * DC + 8);
    for (int i = 0; i < 2 * DC + 8; i++) begin
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL rst_pre cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL rst_pre cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
      @(negedge clk_sys);
    end
    rst_n = 1'b0;
    @(negedge clk_sys);
    if ({AN, cathodes} !== 16'hFFFF) begin miscompares++; $display("FAIL rst_mid_out: got %h want ffff", {AN, cathodes}); end
    vectors++;
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rst_mid_rd: got %h want 0", rd_data); end
    vectors++;
    if (state_dbg !== IDLE) begin miscompares++; $display("FAIL rst_mid_state: got %0d want IDLE", state_dbg); end
    vectors++;
    rst_n = 1'b1;
    push_idle(4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL rst_post cyc %0d: scoreboard empty", i); end
      else begin
        e = exp_q.pop_front(); vectors++;
        if ({AN, cathodes} !== e) begin miscompares++; $display("FAIL rst_post cyc %0d: got %h want %h", i, {AN, cathodes}, e); end
      end
    end
    read_reg(ADDR_VALUE);
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rst_value: got %h want 0", rd_data); end
    vectors++;
    read_reg(ADDR_CTRL);
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rst_ctrl: got %h want 0", rd_data); end
    vectors++;
    read_reg(ADDR_DIGIT_EN);
    if (rd_data !== 32'h0000_00FF) begin miscompares++; $display("FAIL rst_den: got %h want 000000ff", rd_data); end
    vectors++;
  endtask

  // ---------------- sequence and report
  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = 32'h0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    test_reset();
    test_registers();
    test_basic_scan();
    test_pattern();
    test_digit_en();
    test_shadow();
    test_disable_mid();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

endmodule
